// File: rtl/ccu_mu_req_scheduler.sv
// ---------------------------------------------------------------------------
// ccu_mu_req_scheduler
//
// Shares the single memory-unit (MU) op slot among NoReq CCU decode
// requesters. Requesters are granted round-robin. The granted op goes into a
// registered output slot that has a valid/ready handshake. A small table
// tracks writebacks that are still outstanding, keyed by cache line. While a
// line has a writeback pending, any request to that line is held off. New
// writeback ops are also held off while the snoop-data (CD) path is busy or
// the table is full.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i  [NoReq]     request valid per requester
//   req_ready_o  [NoReq]     one-hot grant (combinational)
//   req_op_i     [NoReq*2]   0=READ 1=WB_THEN_READ 2=WRITE 3=WB_THEN_WRITE
//   req_addr_i   [NoReq*AddrWidth]
//   req_first_responder_i [NoReq*MstIdxBits]
//   req_data_available_i  [NoReq*NoMstPorts]
//   mu_valid_o / mu_ready_i  output slot handshake
//   mu_op_o, mu_addr_o, mu_first_responder_o, mu_data_available_o
//                            payload of the granted op
//   mu_src_o                 index of the requester that was granted
//   cd_busy_i                CD path still draining a previous writeback
//   wb_done_i, wb_done_addr_i  writeback completion (frees a table entry)
//   wb_pending_o             number of valid table entries
// ---------------------------------------------------------------------------
module ccu_mu_req_scheduler #(
    parameter int unsigned NoReq      = 2,
    parameter int unsigned NoMstPorts = 4,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned LineOffset = 4,
    parameter int unsigned WbSlots    = 4,
    localparam int unsigned MstIdxBits = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
    localparam int unsigned SrcBits    = (NoReq > 1) ? $clog2(NoReq) : 1,
    localparam int unsigned CntBits    = $clog2(WbSlots + 1),
    localparam int unsigned SlotBits   = (WbSlots > 1) ? $clog2(WbSlots) : 1,
    localparam int unsigned LineW      = AddrWidth - LineOffset
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NoReq-1:0]                req_valid_i,
    output logic [NoReq-1:0]                req_ready_o,
    input  logic [2*NoReq-1:0]              req_op_i,
    input  logic [NoReq*AddrWidth-1:0]      req_addr_i,
    input  logic [NoReq*MstIdxBits-1:0]     req_first_responder_i,
    input  logic [NoReq*NoMstPorts-1:0]     req_data_available_i,
    output logic                            mu_valid_o,
    input  logic                            mu_ready_i,
    output logic [1:0]                      mu_op_o,
    output logic [AddrWidth-1:0]            mu_addr_o,
    output logic [MstIdxBits-1:0]           mu_first_responder_o,
    output logic [NoMstPorts-1:0]           mu_data_available_o,
    output logic [SrcBits-1:0]              mu_src_o,
    input  logic                            cd_busy_i,
    input  logic                            wb_done_i,
    input  logic [AddrWidth-1:0]            wb_done_addr_i,
    output logic [CntBits-1:0]              wb_pending_o
);

    // Unpacked per-requester views of the flat input buses
    logic [1:0]            req_op   [NoReq];
    logic [AddrWidth-1:0]  req_addr [NoReq];
    logic [MstIdxBits-1:0] req_fr   [NoReq];
    logic [NoMstPorts-1:0] req_da   [NoReq];
    logic [LineW-1:0]      req_line [NoReq];

    // Writeback table and arbitration state
    logic [WbSlots-1:0]    tbl_valid_q;
    logic [LineW-1:0]      tbl_line_q [WbSlots];
    logic [CntBits-1:0]    count_q;
    logic [SrcBits-1:0]    rr_q;

    // Output slot
    logic                  vld_p1;
    logic [1:0]            op_p1;
    logic [AddrWidth-1:0]  addr_p1;
    logic [MstIdxBits-1:0] fr_p1;
    logic [NoMstPorts-1:0] da_p1;
    logic [SrcBits-1:0]    src_p1;

    // Combinational decisions
    logic [NoReq-1:0]      hazard;
    logic [NoReq-1:0]      eligible;
    logic                  wb_room;
    logic                  load;
    logic                  grant_found;
    logic [SrcBits-1:0]    grant_idx;
    logic [SrcBits-1:0]    rr_next;
    logic                  do_grant;
    logic                  alloc;
    logic                  alloc_found;
    logic [SlotBits-1:0]   alloc_slot;
    logic                  free_hit;
    logic [SlotBits-1:0]   free_slot;
    logic [LineW-1:0]      done_line;

    // The byte-offset bits of the completion address never affect matching
    logic                  unused_offset_bits;
    assign unused_offset_bits = ^wb_done_addr_i[LineOffset-1:0];

    always_comb begin
        for (int i = 0; i < NoReq; i++) begin
            req_op[i]   = req_op_i[2*i +: 2];
            req_addr[i] = req_addr_i[AddrWidth*i +: AddrWidth];
            req_fr[i]   = req_first_responder_i[MstIdxBits*i +: MstIdxBits];
            req_da[i]   = req_data_available_i[NoMstPorts*i +: NoMstPorts];
            req_line[i] = req_addr_i[AddrWidth*i + LineOffset +: LineW];
        end
    end

    assign done_line = wb_done_addr_i[AddrWidth-1:LineOffset];

    // Hazard checks look only at registered table state, so an entry that
    // is being freed this cycle still blocks its line until the next cycle.
    // The full check likewise uses count_q.
    always_comb begin
        wb_room  = !cd_busy_i && (count_q < CntBits'(WbSlots));
        hazard   = '0;
        eligible = '0;
        for (int i = 0; i < NoReq; i++) begin
            for (int s = 0; s < WbSlots; s++) begin
                if (tbl_valid_q[s] && (tbl_line_q[s] == req_line[i])) begin
                    hazard[i] = 1'b1;
                end
            end
            eligible[i] = req_valid_i[i] && !hazard[i] && (!req_op[i][0] || wb_room);
        end
    end

    // The slot acts as a pipeline register. It can take a new op whenever it
    // is empty or its current op is being consumed.
    assign load = !vld_p1 || mu_ready_i;

    // Round-robin search: first eligible index at or after rr_q
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NoReq; k++) begin
            idx = (int'(rr_q) + k) % int'(NoReq);
            if (!grant_found && eligible[SrcBits'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = SrcBits'(idx);
            end
        end
        rr_next = SrcBits'((int'(grant_idx) + 1) % int'(NoReq));
    end

    assign do_grant = load && grant_found;

    always_comb begin
        req_ready_o = '0;
        if (do_grant && rst_ni) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Allocation uses the lowest invalid entry. A granted WB always has room
    // because the full check is part of eligibility.
    always_comb begin
        alloc_found = 1'b0;
        alloc_slot  = '0;
        for (int s = 0; s < WbSlots; s++) begin
            if (!alloc_found && !tbl_valid_q[s]) begin
                alloc_found = 1'b1;
                alloc_slot  = SlotBits'(s);
            end
        end
        alloc = do_grant && req_op[grant_idx][0] && alloc_found;
    end

    // Entries are unique, so at most one entry can match a completion.
    // A completion with no matching entry is ignored.
    always_comb begin
        free_hit  = 1'b0;
        free_slot = '0;
        for (int s = 0; s < WbSlots; s++) begin
            if (wb_done_i && tbl_valid_q[s] && (tbl_line_q[s] == done_line)) begin
                free_hit  = 1'b1;
                free_slot = SlotBits'(s);
            end
        end
    end

    // ---- stage p1: output slot, round-robin pointer, writeback table ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1      <= 1'b0;
            op_p1       <= '0;
            addr_p1     <= '0;
            fr_p1       <= '0;
            da_p1       <= '0;
            src_p1      <= '0;
            rr_q        <= '0;
            count_q     <= '0;
            tbl_valid_q <= '0;
            for (int s = 0; s < WbSlots; s++) begin
                tbl_line_q[s] <= '0;
            end
        end else begin
            if (load) begin
                vld_p1 <= do_grant;
                if (do_grant) begin
                    op_p1   <= req_op[grant_idx];
                    addr_p1 <= req_addr[grant_idx];
                    fr_p1   <= req_fr[grant_idx];
                    da_p1   <= req_da[grant_idx];
                    src_p1  <= grant_idx;
                    rr_q    <= rr_next;
                end
            end
            // A freed entry was valid and an allocated one was invalid, so
            // the two can never be the same slot.
            if (free_hit) begin
                tbl_valid_q[free_slot] <= 1'b0;
            end
            if (alloc) begin
                tbl_valid_q[alloc_slot] <= 1'b1;
                tbl_line_q[alloc_slot]  <= req_line[grant_idx];
            end
            count_q <= count_q + CntBits'(alloc) - CntBits'(free_hit);
        end
    end

    assign mu_valid_o           = vld_p1;
    assign mu_op_o              = op_p1;
    assign mu_addr_o            = addr_p1;
    assign mu_first_responder_o = fr_p1;
    assign mu_data_available_o  = da_p1;
    assign mu_src_o             = src_p1;
    assign wb_pending_o         = count_q;

endmodule

// File: tb/tb_ccu_mu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ccu_mu_req_scheduler
//
// Randomized and directed stimulus for ccu_mu_req_scheduler. A reference
// model predicts the grant each cycle. The model keeps the outstanding
// writeback lines as a queue and tracks the round-robin pointer as an int.
// Each grant pushes the expected MU op onto a scoreboard queue. A separate
// monitor compares that queue against the MU output slot.
// ---------------------------------------------------------------------------
module tb_ccu_mu_req_scheduler;

    localparam int NoReq      = 2;
    localparam int NoMstPorts = 4;
    localparam int AddrWidth  = 64;
    localparam int LineOffset = 4;
    localparam int WbSlots    = 4;

    logic              clk;
    logic              rst_ni;
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [3:0]        req_op_i;
    logic [127:0]      req_addr_i;
    logic [3:0]        req_first_responder_i;
    logic [7:0]        req_data_available_i;
    logic              mu_valid_o;
    logic              mu_ready_i;
    logic [1:0]        mu_op_o;
    logic [63:0]       mu_addr_o;
    logic [1:0]        mu_first_responder_o;
    logic [3:0]        mu_data_available_o;
    logic [0:0]        mu_src_o;
    logic              cd_busy_i;
    logic              wb_done_i;
    logic [63:0]       wb_done_addr_i;
    logic [2:0]        wb_pending_o;

    ccu_mu_req_scheduler #(
        .NoReq(NoReq), .NoMstPorts(NoMstPorts), .AddrWidth(AddrWidth),
        .LineOffset(LineOffset), .WbSlots(WbSlots)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .req_valid_i           (req_valid_i),
        .req_ready_o           (req_ready_o),
        .req_op_i              (req_op_i),
        .req_addr_i            (req_addr_i),
        .req_first_responder_i (req_first_responder_i),
        .req_data_available_i  (req_data_available_i),
        .mu_valid_o            (mu_valid_o),
        .mu_ready_i            (mu_ready_i),
        .mu_op_o               (mu_op_o),
        .mu_addr_o             (mu_addr_o),
        .mu_first_responder_o  (mu_first_responder_o),
        .mu_data_available_o   (mu_data_available_o),
        .mu_src_o              (mu_src_o),
        .cd_busy_i             (cd_busy_i),
        .wb_done_i             (wb_done_i),
        .wb_done_addr_i        (wb_done_addr_i),
        .wb_pending_o          (wb_pending_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [63:0] addr;
        logic [1:0]  fr;
        logic [3:0]  da;
        logic [0:0]  src;
    } exp_t;

    exp_t        exp_q[$];
    logic [59:0] tbl[$];
    int          rr;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        tbl.delete();
        exp_q.delete();
        rr = 0;
    endtask

    function automatic bit m_elig(input int i);
        logic [59:0] ln;
        bit          hz;
        ln = req_addr_i[64*i + 4 +: 60];
        hz = 1'b0;
        foreach (tbl[j]) if (tbl[j] == ln) hz = 1'b1;
        return req_valid_i[i] && !hz &&
               (!req_op_i[2*i] || (!cd_busy_i && tbl.size() < WbSlots));
    endfunction

    // Called mid-cycle once the inputs are stable. Predicts the grant and
    // advances the model to the state it will hold after the next edge.
    task automatic model_step();
        int          g;
        exp_t        e;
        logic [59:0] dl;
        logic [1:0]  exp_rdy;
        chk("wb_pending", 128'(wb_pending_o), 128'(tbl.size()));
        g = -1;
        // The slot can load only if the monitor has already popped the op it
        // held (empty, or being handed over this cycle).
        if (exp_q.size() == 0) begin
            for (int k = 0; k < NoReq; k++) begin
                int i;
                i = (rr + k) % NoReq;
                if (g < 0 && m_elig(i)) g = i;
            end
        end
        exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
        chk("req_ready", 128'(req_ready_o), 128'(exp_rdy));
        if (wb_done_i) begin
            dl = wb_done_addr_i[63:4];
            for (int j = 0; j < tbl.size(); j++) begin
                if (tbl[j] == dl) begin
                    tbl.delete(j);
                    break;
                end
            end
        end
        if (g >= 0) begin
            e.op   = req_op_i[2*g +: 2];
            e.addr = req_addr_i[64*g +: 64];
            e.fr   = req_first_responder_i[2*g +: 2];
            e.da   = req_data_available_i[4*g +: 4];
            e.src  = 1'(g);
            exp_q.push_back(e);
            if (e.op[0]) tbl.push_back(e.addr[63:4]);
            rr = (g + 1) % NoReq;
        end
    endtask

    task automatic reset_checks();
        chk("rst_req_ready", 128'(req_ready_o), 128'(0));
        chk("rst_mu_valid", 128'(mu_valid_o), 128'(0));
        chk("rst_payload", 128'({mu_op_o, mu_addr_o, mu_first_responder_o,
                                  mu_data_available_o, mu_src_o}), 128'(0));
        chk("rst_wb_pending", 128'(wb_pending_o), 128'(0));
    endtask

    // Inputs are driven at the falling edge. This task checks at +3 and then
    // returns at the next falling edge.
    task automatic cyc();
        #3;
        if (rst_ni) model_step();
        else reset_checks();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input logic [1:0] op, input logic [63:0] a);
        req_valid_i[i]               = v;
        req_op_i[2*i +: 2]           = op;
        req_addr_i[64*i +: 64]       = a;
        req_first_responder_i[2*i +: 2] = 2'($urandom);
        req_data_available_i[4*i +: 4]  = 4'($urandom);
    endtask

    // Monitor: at +1 after each falling edge, checks the output slot against
    // the head of the scoreboard. The head is popped when it is handed over.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_ni) begin
                chk("mu_valid", 128'(mu_valid_o), 128'(exp_q.size() != 0));
                if (mu_valid_o && exp_q.size() > 0) begin
                    chk("mu_payload",
                        128'({mu_op_o, mu_addr_o, mu_first_responder_o, mu_data_available_o, mu_src_o}),
                        128'({exp_q[0].op, exp_q[0].addr, exp_q[0].fr, exp_q[0].da, exp_q[0].src}));
                    if (mu_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_ni = 1'b0;
        mu_ready_i = 1'b1;
        cd_busy_i = 1'b0;
        wb_done_i = 1'b0;
        wb_done_addr_i = '0;
        req_valid_i = '0;
        req_op_i = '0;
        req_addr_i = '0;
        req_first_responder_i = '0;
        req_data_available_i = '0;
        @(negedge clk);

        // Requests are pending during reset, but no ready may be raised
        set_req(0, 1, 2'd0, 64'h100);
        set_req(1, 1, 2'd0, 64'h200);
        repeat (3) cyc();
        rst_ni = 1'b1;
        model_reset();

        // Two READ streams with the MU always ready: grants alternate
        for (int n = 0; n < 8; n++) begin
            set_req(0, 1, 2'd0, 64'h400 + 64'(n * 16));
            set_req(1, 1, 2'd0, 64'h800 + 64'(n * 16));
            cyc();
        end
        req_valid_i = '0;
        repeat (2) cyc();

        // A writeback to line 0x100 blocks a WRITE to 0x1008 until it completes
        set_req(0, 1, 2'd1, 64'h1000);
        cyc();
        chk("pending_one", 128'(wb_pending_o), 128'(1));
        set_req(0, 0, 2'd0, 64'h0);
        set_req(1, 1, 2'd2, 64'h1008);
        repeat (4) cyc();
        wb_done_i = 1'b1;
        wb_done_addr_i = 64'h1000;
        cyc();
        wb_done_i = 1'b0;
        cyc();
        chk("pending_zero", 128'(wb_pending_o), 128'(0));
        req_valid_i = '0;
        cyc();

        // MU stall: the payload must hold and no request may be accepted
        set_req(0, 1, 2'd0, 64'h2000);
        set_req(1, 1, 2'd2, 64'h2100);
        mu_ready_i = 1'b0;
        repeat (6) cyc();
        mu_ready_i = 1'b1;
        repeat (3) cyc();
        req_valid_i = '0;
        repeat (2) cyc();

        // Fill the table, then stall a fifth WB while a READ still gets through
        for (int n = 0; n < 4; n++) begin
            set_req(0, 1, 2'd1, 64'h3000 + 64'(n * 16));
            cyc();
        end
        req_valid_i = '0;
        chk("pending_full", 128'(wb_pending_o), 128'(4));
        set_req(0, 1, 2'd3, 64'h3040);
        set_req(1, 1, 2'd0, 64'h4000);
        repeat (3) cyc();
        wb_done_i = 1'b1;
        wb_done_addr_i = 64'h3024;
        cyc();
        wb_done_i = 1'b0;
        repeat (2) cyc();
        req_valid_i = '0;

        // Drain every outstanding writeback
        for (int guard = 0; guard < 2 * WbSlots && tbl.size() > 0; guard++) begin
            wb_done_i = 1'b1;
            wb_done_addr_i = {tbl[0], 4'h0};
            cyc();
        end
        wb_done_i = 1'b0;
        cyc();

        // CD path busy holds off a WB_THEN_WRITE; it goes as soon as the path frees
        cd_busy_i = 1'b1;
        set_req(0, 1, 2'd3, 64'h5000);
        repeat (3) cyc();
        cd_busy_i = 1'b0;
        cyc();
        req_valid_i = '0;
        chk("cd_grant_valid", 128'(mu_valid_o), 128'(1));
        cyc();

        // Completion for an unknown line changes nothing
        wb_done_i = 1'b1;
        wb_done_addr_i = 64'hDEAD0;
        cyc();
        wb_done_i = 1'b0;
        chk("unknown_done", 128'(wb_pending_o), 128'(1));

        // Reset in the middle of a stall with a WB outstanding
        set_req(1, 1, 2'd1, 64'h6000);
        mu_ready_i = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b1;
        model_reset();
        req_valid_i = '0;
        mu_ready_i = 1'b1;
        cyc();
        chk("post_rst_pending", 128'(wb_pending_o), 128'(0));

        // Random traffic over a small pool of lines to force hazards
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NoReq; i++) begin
                set_req(i, $urandom_range(0, 3) != 0, 2'($urandom),
                        64'h8000 + 64'($urandom_range(0, 7) * 16) + 64'($urandom_range(0, 15)));
            end
            cd_busy_i  = ($urandom_range(0, 3) == 0);
            mu_ready_i = ($urandom_range(0, 3) != 0);
            wb_done_i  = ($urandom_range(0, 2) == 0);
            if (tbl.size() > 0 && $urandom_range(0, 3) != 0)
                wb_done_addr_i = {tbl[$urandom_range(0, tbl.size() - 1)], 4'($urandom)};
            else
                wb_done_addr_i = 64'h8000 + 64'($urandom_range(0, 7) * 16);
            cyc();
        end
        req_valid_i = '0;
        wb_done_i = 1'b0;
        mu_ready_i = 1'b1;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ccu_mu_req_scheduler.md
Name: ccu_mu_req_scheduler

Overview:
- Arbitrates between NoReq CCU decode requesters (e.g. read path, write path) for the single memory unit (MU) operation slot.
- Grants round-robin and delivers the granted op through a registered output slot with a valid/ready handshake.
- Tracks outstanding writebacks by cache-line address and blocks any request to a line with a pending writeback.
- Also blocks new writeback ops while the snoop-data (CD) path is busy or the writeback table is full.

Parameters:
- NoReq, 2, number of requesters.
- NoMstPorts, 4, snooped master ports; MstIdxBits = $clog2(NoMstPorts).
- AddrWidth, 64, request address width.
- LineOffset, 4, byte-offset bits of a cache line; line = addr[AddrWidth-1:LineOffset].
- WbSlots, 4, max outstanding writebacks (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NoReq  request valid per requester.
- req_ready_o  out  NoReq  request accepted (granted) this cycle.
- req_op_i  in  NoReq x 2  op: 0=READ, 1=WB_THEN_READ, 2=WRITE, 3=WB_THEN_WRITE.
- req_addr_i  in  NoReq x AddrWidth  request address.
- req_first_responder_i  in  NoReq x MstIdxBits  snoop responder supplying dirty data.
- req_data_available_i  in  NoReq x NoMstPorts  ports returning CD data.
- mu_valid_o  out  1  output slot valid.
- mu_ready_i  in  1  MU accepts op.
- mu_op_o  out  2  op, same encoding as req_op_i.
- mu_addr_o  out  AddrWidth  address.
- mu_first_responder_o  out  MstIdxBits  responder.
- mu_data_available_o  out  NoMstPorts  data-available mask.
- mu_src_o  out  $clog2(NoReq) (min 1)  index of the granted requester.
- cd_busy_i  in  1  CD path still draining a previous writeback.
- wb_done_i  in  1  a writeback B response completed.
- wb_done_addr_i  in  AddrWidth  address of the completed writeback.
- wb_pending_o  out  $clog2(WbSlots+1)  number of valid table entries.

Behaviour:
- Reset values:
  - mu_valid_o=0; all mu_* payload outputs=0.
  - Round-robin pointer=0.
  - All table entries invalid; wb_pending_o=0.
  - req_ready_o is combinational; it is 0 while in reset.
- is_wb = op[0]. The table is WbSlots entries of {valid, line}.
- hazard[i]: req line equals the line of any valid entry in the registered table state. An entry freed this cycle still blocks this cycle.
- eligible[i] = req_valid_i[i] & !hazard[i] & (!is_wb[i] | (!cd_busy_i & count_q < WbSlots)).
- Slot load condition: load = !mu_valid_o | mu_ready_i. The slot behaves as a pipeline register, with no bubble on back-to-back ops.
- When load is true and any requester is eligible:
  - Grant the first eligible index at or after the rr pointer, wrapping modulo NoReq.
  - At most one req_ready_o bit is high per cycle.
  - On the next edge: mu_* <= granted payload, mu_src_o <= index, mu_valid_o <= 1, rr pointer <= (index+1) mod NoReq.
- When load is true and no requester is eligible: mu_valid_o <= 0 on the next edge.
- When load is false: the slot holds; mu_valid_o and the payload stay stable until mu_ready_i.
- Latency: a request accepted in cycle N appears on mu_valid_o in cycle N+1.
- Table allocation: on a granted WB op, write {1, line} to the lowest-index invalid entry. Entries are unique because duplicates are blocked by hazard.
- Table free: when wb_done_i is high, clear the entry whose line matches wb_done_addr_i.
  - No match: ignored; no state change.
- Free and allocation in the same cycle are both applied.
  - Full check uses count_q, so a slot freed this cycle is not reusable until the next cycle.
  - count_d = count_q + alloc - free.
- A request withdrawn (valid low) before grant is legal. The rr pointer only moves on a grant.
- Reset mid-operation: everything clears. Table contents are lost; the environment resets the MU and memory path together.

Test Plan:
- Both requesters valid with READ, mu_ready_i=1 held → grants alternate 0,1,0,1; mu_valid_o stays 1 every cycle after the first; mu_src_o alternates.
- Req0 WB_THEN_READ at 0x1000, then req1 WRITE at 0x1008 → req1 stays blocked until wb_done_i with addr 0x1000; it is granted the cycle after, and wb_pending_o goes 1→0.
- mu_ready_i=0 for 5 cycles with mu_valid_o=1 → payload is stable and req_ready_o=0 throughout; mu_ready_i=1 → the next eligible op loads on the same edge.
- Four WB ops to distinct lines → wb_pending_o=4; a fifth WB is stalled while a READ from the other requester is still granted; wb_done_i on any line → the fifth WB is granted one cycle later.
- cd_busy_i=1 with WB_THEN_WRITE pending → no grant; deassert cd_busy_i → grant in the same cycle, mu_valid_o=1 on the next cycle.
- wb_done_i for an unknown address, and reset asserted mid-stall → no table change for the unknown address; after reset, outputs are 0 and wb_pending_o=0.
